fetch_redirect_ctrl: RTL and testbench

- Next-PC sequencer for the RV32I fetch stage.
- Owns the fetch PC register and issues word requests to instruction memory over a req/ack handshake.
- Drives the source-select of the immediate adder (PC vs rs1) and consumes its target when a branch or jump is taken.
- Handles redirects, pipeline flush bubbles, misaligned-target traps and decode back-pressure through a one-entry skid buffer.

---
 rtl/fetch_redirect_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: next-PC sequencer for the RV32I fetch stage.
//
// Owns the fetch PC, issues word fetches over a req/ack bus, selects the
// immediate-adder source (PC or rs1), and applies taken branches, jumps and
// misaligned-target traps. A one-entry skid buffer absorbs a fetch that
// returns while decode is stalled.
//
// Handshakes:
//   imem bus : imem_req_out rises with imem_addr_out and both hold steady
//              until a cycle with imem_ack_in=1, which completes the request
//              and supplies imem_rdata_in. A request is never withdrawn.
//   decode   : an instruction is handed over on each rising edge where
//              valid_out=1 and stall_in=0.
//
// Ports:
//   clk_in, rst_in              clock (rising edge), async active-low reset
//   stall_in                    decode cannot accept an instruction
//   branch_taken_in, jump_in,   redirect requests; target on iaddr_in
//   jalr_in, iaddr_in
//   iaddr_src_out               adder source select (1 = rs1, follows jalr_in)
//   imem_req_out/addr_out/      instruction memory request side
//   ack_in/rdata_in
//   instr_out, pc_out, valid_out  instruction to decode
//   flush_out                   kill younger pipeline stages
//   misaligned_out, epc_out     one-cycle trap pulse and offending target
//   dbg_state_out               current sequencer state (debug)
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic        jump_in,
  input  logic        jalr_in,
  input  logic [31:0] iaddr_in,
  output logic        iaddr_src_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        flush_out,
  output logic        misaligned_out,
  output logic [31:0] epc_out,
  output logic [1:0]  dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;

  logic        skid_valid_q;
  logic [31:0] skid_instr_q, skid_pc_q;
  logic [31:0] target_q;
  logic [2:0]  flush_cnt_q;

  logic        req_d, valid_d, flush_d, mis_d, skid_valid_d;
  logic [31:0] addr_d, instr_d, pc_d, epc_d, target_d, skid_instr_d, skid_pc_d;
  logic [2:0]  flush_cnt_d;

  logic        redirect, trap, ack_live, consume;
  logic [31:0] target;

  assign iaddr_src_out = jalr_in;
  assign dbg_state_out = state_q;

  // Redirects are only meaningful once the sequencer has left IDLE.
  assign redirect = (state_q != S_IDLE) & (branch_taken_in | jump_in | jalr_in);
  assign target   = jalr_in ? {iaddr_in[31:1], 1'b0} : iaddr_in;
  assign trap     = redirect & target[1];
  // An ack in FLUSH (or alongside a redirect) belongs to a killed fetch.
  assign ack_live = (state_q == S_REQ) & imem_req_out & imem_ack_in & ~redirect;
  assign consume  = valid_out & ~stall_in;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (redirect) state_d = S_FLUSH;
        // Data that cannot be delivered lands in (or already sits in) the
        // skid; stop requesting until decode drains it.
        else if (stall_in && valid_out && (ack_live || skid_valid_q)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)          state_d = S_FLUSH;
        else if (!skid_valid_q) state_d = S_REQ;
      end
      S_FLUSH: begin
        if (redirect) state_d = S_FLUSH;
        // Leave only once the bubble count is spent and any killed fetch has
        // been acked, so the bus is never aborted.
        else if (flush_cnt_q == 3'd0 && !imem_req_out) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    // A request stays up while unacked, and is (re)raised whenever REQ is entered.
    req_d = (state_d == S_REQ) | (imem_req_out & ~imem_ack_in);

    addr_d = imem_addr_out;
    if (ack_live)                                       addr_d = imem_addr_out + 32'd4;
    else if (state_q == S_FLUSH && state_d == S_REQ)    addr_d = target_q;

    target_d = target_q;
    if (redirect) target_d = trap ? TRAP_VEC : target;

    flush_cnt_d = flush_cnt_q;
    flush_d     = 1'b0;
    if (redirect) begin
      flush_cnt_d = FLUSH_LOAD;
      flush_d     = 1'b1;
    end else if (state_q == S_FLUSH && flush_cnt_q != 3'd0) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
      flush_d     = (flush_cnt_q != 3'd1);
    end

    mis_d = trap;
    epc_d = trap ? target : epc_out;

    instr_d      = instr_out;
    pc_d         = pc_out;
    valid_d      = valid_out;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (redirect) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      if (skid_valid_q && (consume || !valid_out)) begin
        // Skid drains into the output; a same-cycle ack refills the skid.
        instr_d      = skid_instr_q;
        pc_d         = skid_pc_q;
        valid_d      = 1'b1;
        skid_valid_d = ack_live;
        if (ack_live) begin
          skid_instr_d = imem_rdata_in;
          skid_pc_d    = imem_addr_out;
        end
      end else if (ack_live && (!stall_in || !valid_out)) begin
        instr_d = imem_rdata_in;
        pc_d    = imem_addr_out;
        valid_d = 1'b1;
      end else if (ack_live) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata_in;
        skid_pc_d    = imem_addr_out;
      end else if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      imem_req_out   <= 1'b0;
      imem_addr_out  <= RESET_PC;
      instr_out      <= NOP;
      pc_out         <= RESET_PC;
      valid_out      <= 1'b0;
      flush_out      <= 1'b0;
      misaligned_out <= 1'b0;
      epc_out        <= 32'h0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= NOP;
      skid_pc_q      <= RESET_PC;
      target_q       <= RESET_PC;
      flush_cnt_q    <= 3'd0;
    end else begin
      imem_req_out   <= req_d;
      imem_addr_out  <= addr_d;
      instr_out      <= instr_d;
      pc_out         <= pc_d;
      valid_out      <= valid_d;
      flush_out      <= flush_d;
      misaligned_out <= mis_d;
      epc_out        <= epc_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      target_q       <= target_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl. Inputs change just after the rising
// edge; the reference model and the decode-side monitor both sample on the
// falling edge, where everything the next rising edge will act on is stable.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in, branch_taken_in, jump_in, jalr_in;
  logic [31:0] iaddr_in;
  logic        iaddr_src_out, imem_req_out, imem_ack_in;
  logic [31:0] imem_addr_out, imem_rdata_in;
  logic [31:0] instr_out, pc_out, epc_out;
  logic        valid_out, flush_out, misaligned_out;
  logic [1:0]  dbg_state_out;

  fetch_redirect_ctrl #(
    .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .branch_taken_in(branch_taken_in), .jump_in(jump_in), .jalr_in(jalr_in),
    .iaddr_in(iaddr_in), .iaddr_src_out(iaddr_src_out),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .flush_out(flush_out), .misaligned_out(misaligned_out), .epc_out(epc_out),
    .dbg_state_out(dbg_state_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  int ack_pct   = 100;
  int stall_pct = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // kind: 0 = branch, 1 = JAL, 2 = JALR; held for exactly one edge.
  task automatic redirect(input int kind, input logic [31:0] addr);
    iaddr_in        = addr;
    branch_taken_in = (kind == 0);
    jump_in         = (kind == 1);
    jalr_in         = (kind == 2);
    tick();
    branch_taken_in = 1'b0;
    jump_in         = 1'b0;
    jalr_in         = 1'b0;
  endtask

  function automatic logic [31:0] rand_target(input int kind);
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6)       r[1:0] = 2'b00;
    else if (sel == 6) r = 32'hFFFF_FFF0 + {28'h0, r[1:0], 2'b00};
    else if (sel == 7) r[1:0] = 2'b10;          // misaligned
    else               r[1:0] = 2'b01;          // odd: JALR clears bit 0
    if (kind != 2) r[0] = 1'b0;
    return r;
  endfunction

  // Memory / decode-side driver: random acks and stalls.
  initial begin
    imem_ack_in   = 1'b0;
    imem_rdata_in = 32'h0;
    stall_in      = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      imem_ack_in   = imem_req_out && ($urandom_range(1, 100) <= ack_pct);
      imem_rdata_in = $urandom;
      stall_in      = ($urandom_range(1, 100) <= stall_pct);
    end
  end

  // ---------------- reference model ----------------
  // Fetch stream: consecutive words from the current PC; a redirect restarts
  // the stream at its target (or the trap vector) and kills everything not
  // yet handed to decode, including a fetch still in flight on the bus.
  logic [63:0] exp_q[$];       // {pc, instr} awaiting hand-over to decode
  logic [31:0] model_pc;
  int          flush_left;
  logic        mis_exp;
  logic [31:0] epc_exp;
  logic        drop_ack;
  int          n_fetch = 0;
  logic        m_redir, m_hs;
  logic [31:0] m_tgt;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      model_pc   = RESET_PC;
      flush_left = 0;
      mis_exp    = 1'b0;
      epc_exp    = 32'h0;
      drop_ack   = 1'b0;
      exp_q.delete();
    end else begin
      m_redir = branch_taken_in | jump_in | jalr_in;
      m_hs    = imem_req_out & imem_ack_in;

      check("iaddr_src_out", {31'h0, iaddr_src_out}, {31'h0, jalr_in});
      check("flush_out", {31'h0, flush_out}, {31'h0, flush_left > 0});
      check("misaligned_out", {31'h0, misaligned_out}, {31'h0, mis_exp});
      check("epc_out", epc_out, epc_exp);
      if (flush_left > 0) begin
        check("valid_in_flush", {31'h0, valid_out}, 32'h0);
        if (!drop_ack) check("req_in_flush", {31'h0, imem_req_out}, 32'h0);
      end

      if (m_hs) begin
        if (drop_ack) drop_ack = 1'b0;
        else begin
          check("imem_addr", imem_addr_out, model_pc);
          if (!m_redir) begin
            exp_q.push_back({model_pc, imem_rdata_in});
            n_fetch++;
          end
          model_pc = model_pc + 32'd4;
        end
      end

      mis_exp = 1'b0;
      if (flush_left > 0) flush_left--;
      if (m_redir) begin
        m_tgt = iaddr_in;
        if (jalr_in) m_tgt[0] = 1'b0;
        exp_q.delete();
        flush_left = FLUSH_CYCLES;
        drop_ack   = imem_req_out & ~imem_ack_in;
        if (m_tgt[1]) begin
          mis_exp  = 1'b1;
          epc_exp  = m_tgt;
          model_pc = TRAP_VEC;
        end else begin
          model_pc = m_tgt;
        end
      end
    end
  end

  // ---------------- decode-side monitor ----------------
  logic [63:0] mon_e;
  always @(negedge clk_in) begin
    if (rst_in && valid_out && !stall_in && !(branch_taken_in | jump_in | jalr_in)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc_out %h, required no live instruction", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc_out", pc_out, mon_e[63:32]);
        check("instr_out", instr_out, mon_e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    branch_taken_in = 1'b0;
    jump_in         = 1'b0;
    jalr_in         = 1'b0;
    iaddr_in        = 32'h0;
    rst_in          = 1'b0;
    repeat (3) tick();

    check("rst_req", {31'h0, imem_req_out}, 32'h0);
    check("rst_addr", imem_addr_out, RESET_PC);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_instr", instr_out, NOP);
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_flush", {31'h0, flush_out}, 32'h0);
    check("rst_mis", {31'h0, misaligned_out}, 32'h0);
    check("rst_epc", epc_out, 32'h0);
    rst_in = 1'b1;

    // Sequential fetch with prompt acks.
    ack_pct = 100; stall_pct = 0;
    repeat (6) tick();

    // Taken branch, then back-to-back redirects (second lands in FLUSH).
    redirect(0, 32'h0000_0040);
    repeat (8) tick();
    redirect(0, 32'h0000_0200);
    redirect(1, 32'h0000_0300);
    repeat (8) tick();

    // JALR to a misaligned target -> trap to TRAP_VEC.
    redirect(2, 32'h0000_1003);
    repeat (8) tick();

    // Decode stalled: output and skid fill, requests must stop.
    stall_pct = 100;
    repeat (8) tick();
    check("no_req_when_full", {31'h0, imem_req_out}, 32'h0);
    check("valid_held", {31'h0, valid_out}, 32'h1);
    stall_pct = 0;
    repeat (6) tick();

    // Async reset in the middle of an outstanding request at 0x20.
    redirect(0, 32'h0000_0020);
    tick();
    ack_pct = 0;
    repeat (5) tick();
    check("req_pending", {31'h0, imem_req_out}, 32'h1);
    check("req_addr_20", imem_addr_out, 32'h0000_0020);
    #2;
    rst_in          = 1'b0;
    branch_taken_in = 1'b1;     // must be ignored under reset
    iaddr_in        = 32'h0000_0080;
    #1;
    check("async_rst_req", {31'h0, imem_req_out}, 32'h0);
    check("async_rst_valid", {31'h0, valid_out}, 32'h0);
    check("async_rst_addr", imem_addr_out, RESET_PC);
    repeat (2) tick();
    branch_taken_in = 1'b0;
    rst_in  = 1'b1;
    ack_pct = 100;
    repeat (6) tick();

    // Address wrap at the top of memory.
    redirect(1, 32'hFFFF_FFFC);
    repeat (8) tick();

    // Randomized traffic.
    for (int blk = 0; blk < 15; blk++) begin
      ack_pct   = $urandom_range(30, 100);
      stall_pct = $urandom_range(0, 60);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 99) < 4) begin
          int kind;
          kind = $urandom_range(0, 2);
          redirect(kind, rand_target(kind));
        end else begin
          tick();
        end
      end
    end

    // Drain: no new fetches, decode ready.
    stall_pct = 0;
    ack_pct   = 0;
    repeat (12) tick();
    check("drain_empty", exp_q.size(), 32'h0);
    check("drain_valid", {31'h0, valid_out}, 32'h0);
    check("fetch_progress", {31'h0, n_fetch > 300}, 32'h1);

    $display("fetched %0d words, final sequencer state %0d", n_fetch, dbg_state_out);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
